// File: rtl/pf_lanectrl_dly_seq.sv
// Delay-line update sequencer: one move/load request at a time, wrapped in a per-lane HS_IO_CLK_PAUSE window.
// Latency accept->DONE: move 1+PRE+N+(N-1)*GAP+POST, load 2+PRE+POST; REQ_READY high only in IDLE.
module pf_lanectrl_dly_seq #(
    parameter int NUM_LANES  = 4,
    parameter int LANE_W     = 2,
    parameter int CNT_W      = 8,
    parameter int PAUSE_PRE  = 2,
    parameter int PAUSE_POST = 2,
    parameter int MOVE_GAP   = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [LANE_W-1:0]    REQ_LANE,
    input  logic [1:0]           REQ_OP,
    input  logic                 REQ_TX,
    input  logic                 REQ_DIR,
    input  logic [CNT_W-1:0]     REQ_STEPS,
    input  logic [NUM_LANES-1:0] OUT_OF_RANGE,
    output logic [NUM_LANES-1:0] DELAY_LINE_SEL,
    output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
    output logic                 DONE,
    output logic [CNT_W-1:0]     DONE_STEPS,
    output logic                 DONE_OOR,
    output logic                 DONE_ERR
);

    localparam int TMR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_GAP,
        S_POST,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic               hit_q, hit_d;
    logic               act_oor_q, act_oor_d;

    logic [LANE_W-1:0]  lane_q;
    logic               load_q, tx_q, dir_q;
    logic [CNT_W-1:0]   steps_q;

    logic               accept, req_err, busy_d;
    logic [LANE_W-1:0]  cur_lane;
    logic               cur_load, cur_tx, cur_dir;

    logic [NUM_LANES-1:0] pause_d, sel_d, dir_d, load_d, move_d;

    assign REQ_READY = (state_q == S_IDLE);

    // In IDLE the outputs for the first PRE cycle come straight from the request inputs.
    always_comb begin
        accept   = REQ_VALID && (state_q == S_IDLE);
        req_err  = REQ_OP[1] || (32'(REQ_LANE) >= 32'(NUM_LANES));
        cur_lane = lane_q;
        cur_load = load_q;
        cur_tx   = tx_q;
        cur_dir  = dir_q;
        if (state_q == S_IDLE) begin
            cur_lane = REQ_LANE;
            cur_load = (REQ_OP == 2'b01);
            cur_tx   = REQ_TX;
            cur_dir  = REQ_DIR;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        issued_d = issued_q;
        hit_d    = hit_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    issued_d = '0;
                    hit_d    = 1'b0;
                    if (req_err || ((REQ_OP == 2'b00) && (REQ_STEPS == '0))) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PRE;
                        tmr_d   = TMR_W'(PAUSE_PRE - 1);
                    end
                end
            end
            S_PRE: begin
                if (tmr_q == '0) state_d = S_ACT;
                else             tmr_d   = tmr_q - 1'b1;
            end
            S_ACT: begin
                if (load_q) begin
                    state_d = S_POST;
                    tmr_d   = TMR_W'(PAUSE_POST - 1);
                end else if (act_oor_q) begin
                    hit_d   = 1'b1;
                    state_d = S_POST;
                    tmr_d   = TMR_W'(PAUSE_POST - 1);
                end else begin
                    // issued < steps here, so the increment cannot wrap
                    issued_d = issued_q + 1'b1;
                    if (issued_d == steps_q) begin
                        state_d = S_POST;
                        tmr_d   = TMR_W'(PAUSE_POST - 1);
                    end else begin
                        state_d = S_GAP;
                        tmr_d   = TMR_W'(MOVE_GAP - 1);
                    end
                end
            end
            S_GAP: begin
                if (tmr_q == '0) state_d = S_ACT;
                else             tmr_d   = tmr_q - 1'b1;
            end
            S_POST: begin
                if (tmr_q == '0) state_d = S_DONE;
                else             tmr_d   = tmr_q - 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state; OUT_OF_RANGE is sampled on the edge that enters ACT,
    // so the same sample both suppresses the MOVE pulse and steers ACT to POST.
    always_comb begin
        busy_d    = (state_d == S_PRE) || (state_d == S_ACT) ||
                    (state_d == S_GAP) || (state_d == S_POST);
        pause_d   = '0;
        sel_d     = '0;
        dir_d     = '0;
        load_d    = '0;
        move_d    = '0;
        act_oor_d = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (cur_lane == LANE_W'(i)) begin
                pause_d[i] = busy_d;
                sel_d[i]   = busy_d && cur_tx;
                dir_d[i]   = busy_d && cur_dir;
                load_d[i]  = (state_d == S_ACT) && cur_load;
                move_d[i]  = (state_d == S_ACT) && !cur_load && !OUT_OF_RANGE[i];
                act_oor_d  = OUT_OF_RANGE[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q              <= S_IDLE;
            tmr_q                <= '0;
            issued_q             <= '0;
            hit_q                <= 1'b0;
            act_oor_q            <= 1'b0;
            lane_q               <= '0;
            load_q               <= 1'b0;
            tx_q                 <= 1'b0;
            dir_q                <= 1'b0;
            steps_q              <= '0;
            HS_IO_CLK_PAUSE      <= '0;
            DELAY_LINE_SEL       <= '0;
            DELAY_LINE_DIRECTION <= '0;
            DELAY_LINE_LOAD      <= '0;
            DELAY_LINE_MOVE      <= '0;
            DONE                 <= 1'b0;
            DONE_STEPS           <= '0;
            DONE_OOR             <= 1'b0;
            DONE_ERR             <= 1'b0;
        end else begin
            state_q              <= state_d;
            tmr_q                <= tmr_d;
            issued_q             <= issued_d;
            hit_q                <= hit_d;
            act_oor_q            <= act_oor_d;
            HS_IO_CLK_PAUSE      <= pause_d;
            DELAY_LINE_SEL       <= sel_d;
            DELAY_LINE_DIRECTION <= dir_d;
            DELAY_LINE_LOAD      <= load_d;
            DELAY_LINE_MOVE      <= move_d;
            DONE                 <= (state_d == S_DONE);
            if (accept) begin
                lane_q  <= REQ_LANE;
                load_q  <= (REQ_OP == 2'b01);
                tx_q    <= REQ_TX;
                dir_q   <= REQ_DIR;
                steps_q <= REQ_STEPS;
            end
            if (state_d == S_DONE) begin
                DONE_STEPS <= issued_d;
                DONE_OOR   <= hit_d;
                DONE_ERR   <= accept && req_err;
            end
        end
    end

endmodule

// File: tb/tb_pf_lanectrl_dly_seq.sv
// Directed bench for pf_lanectrl_dly_seq: 4 lanes, 3-bit lane index so out-of-range lanes can be requested.
module tb_pf_lanectrl_dly_seq;

    logic       CLK;
    logic       RESET_N;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [2:0] REQ_LANE;
    logic [1:0] REQ_OP;
    logic       REQ_TX;
    logic       REQ_DIR;
    logic [7:0] REQ_STEPS;
    logic [3:0] OUT_OF_RANGE;
    logic [3:0] DELAY_LINE_SEL;
    logic [3:0] DELAY_LINE_DIRECTION;
    logic [3:0] DELAY_LINE_LOAD;
    logic [3:0] DELAY_LINE_MOVE;
    logic [3:0] HS_IO_CLK_PAUSE;
    logic       DONE;
    logic [7:0] DONE_STEPS;
    logic       DONE_OOR;
    logic       DONE_ERR;

    int errors = 0;
    int checks = 0;

    pf_lanectrl_dly_seq #(
        .NUM_LANES (4),
        .LANE_W    (3),
        .CNT_W     (8),
        .PAUSE_PRE (2),
        .PAUSE_POST(2),
        .MOVE_GAP  (1)
    ) dut (
        .CLK                 (CLK),
        .RESET_N             (RESET_N),
        .REQ_VALID           (REQ_VALID),
        .REQ_READY           (REQ_READY),
        .REQ_LANE            (REQ_LANE),
        .REQ_OP              (REQ_OP),
        .REQ_TX              (REQ_TX),
        .REQ_DIR             (REQ_DIR),
        .REQ_STEPS           (REQ_STEPS),
        .OUT_OF_RANGE        (OUT_OF_RANGE),
        .DELAY_LINE_SEL      (DELAY_LINE_SEL),
        .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD     (DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE     (DELAY_LINE_MOVE),
        .HS_IO_CLK_PAUSE     (HS_IO_CLK_PAUSE),
        .DONE                (DONE),
        .DONE_STEPS          (DONE_STEPS),
        .DONE_OOR            (DONE_OOR),
        .DONE_ERR            (DONE_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Presents a request in the current (IDLE) cycle T0; returns in cycle T1 with inputs scrambled.
    task automatic issue(input int lane, input logic [1:0] op, input bit tx, input bit dir, input int steps);
        REQ_LANE  = 3'(lane);
        REQ_OP    = op;
        REQ_TX    = tx;
        REQ_DIR   = dir;
        REQ_STEPS = 8'(steps);
        REQ_VALID = 1'b1;
        chk("ready_at_accept", 32'(REQ_READY), 32'd1);
        step();
        REQ_VALID = 1'b0;
        REQ_LANE  = 3'd6;
        REQ_OP    = 2'b11;
        REQ_TX    = ~tx;
        REQ_DIR   = ~dir;
        REQ_STEPS = 8'd0;
        chk("ready_after_accept", 32'(REQ_READY), 32'd0);
    endtask

    // Checks every cycle T1..DONE of a normal load or move (no out-of-range), then the IDLE cycle after.
    task automatic expect_op(input string tag, input int lane, input bit is_load, input bit tx,
                             input bit dir, input int n);
        int d;
        logic [3:0] m, ep, ev, el;
        d = is_load ? 6 : (2 * n + 4);
        m = 4'b0001 << lane;
        for (int t = 1; t <= d; t++) begin
            ep = (t <= d - 1) ? m : 4'b0000;
            ev = (!is_load && t >= 3 && t <= 2 * n + 1 && (t % 2) == 1) ? m : 4'b0000;
            el = (is_load && t == 3) ? m : 4'b0000;
            chk({tag, "_pause"}, 32'(HS_IO_CLK_PAUSE), 32'(ep));
            chk({tag, "_sel"},   32'(DELAY_LINE_SEL), 32'(tx ? ep : 4'b0000));
            chk({tag, "_dir"},   32'(DELAY_LINE_DIRECTION), 32'(dir ? ep : 4'b0000));
            chk({tag, "_move"},  32'(DELAY_LINE_MOVE), 32'(ev));
            chk({tag, "_load"},  32'(DELAY_LINE_LOAD), 32'(el));
            chk({tag, "_done"},  32'(DONE), 32'(t == d));
            if (t == d) begin
                chk({tag, "_done_steps"}, 32'(DONE_STEPS), 32'(is_load ? 0 : n));
                chk({tag, "_done_oor"},   32'(DONE_OOR), 32'd0);
                chk({tag, "_done_err"},   32'(DONE_ERR), 32'd0);
            end
            step();
        end
        chk({tag, "_ready_after"}, 32'(REQ_READY), 32'd1);
        chk({tag, "_done_drop"},   32'(DONE), 32'd0);
    endtask

    initial begin
        int pulses;
        RESET_N      = 1'b0;
        REQ_VALID    = 1'b0;
        REQ_LANE     = 3'd0;
        REQ_OP       = 2'b00;
        REQ_TX       = 1'b0;
        REQ_DIR      = 1'b0;
        REQ_STEPS    = 8'd0;
        OUT_OF_RANGE = 4'b0000;

        // Reset state
        step();
        chk("rst_ready", 32'(REQ_READY), 32'd1);
        chk("rst_pause", 32'(HS_IO_CLK_PAUSE), 32'd0);
        chk("rst_move",  32'(DELAY_LINE_MOVE), 32'd0);
        chk("rst_done",  32'(DONE), 32'd0);
        chk("rst_steps", 32'(DONE_STEPS), 32'd0);
        step();
        RESET_N = 1'b1;
        step();

        // Lane 2 move, 3 steps; other lanes' out-of-range flags must not matter
        OUT_OF_RANGE = 4'b1011;
        issue(2, 2'b00, 1'b1, 1'b1, 3);
        expect_op("mv3", 2, 1'b0, 1'b1, 1'b1, 3);
        OUT_OF_RANGE = 4'b0000;

        // Lane 1 load
        issue(1, 2'b01, 1'b0, 1'b1, 7);
        expect_op("ld1", 1, 1'b1, 1'b0, 1'b1, 0);

        // Lane 0 move of 5, out-of-range rises after the second pulse
        issue(0, 2'b00, 1'b0, 1'b1, 5);
        pulses = 0;
        for (int t = 1; t <= 10; t++) begin
            if (DELAY_LINE_MOVE[0] === 1'b1) pulses++;
            chk("oor_pause", 32'(HS_IO_CLK_PAUSE), 32'(t <= 9 ? 4'b0001 : 4'b0000));
            chk("oor_move",  32'(DELAY_LINE_MOVE), 32'((t == 3 || t == 5) ? 4'b0001 : 4'b0000));
            chk("oor_done",  32'(DONE), 32'(t == 10));
            if (t == 5) OUT_OF_RANGE = 4'b0001;
            if (t == 10) begin
                chk("oor_done_steps", 32'(DONE_STEPS), 32'd2);
                chk("oor_done_oor",   32'(DONE_OOR), 32'd1);
                chk("oor_done_err",   32'(DONE_ERR), 32'd0);
            end
            step();
        end
        chk("oor_pulse_count", 32'(pulses), 32'd2);
        OUT_OF_RANGE = 4'b0000;

        // Bad lane index
        issue(5, 2'b00, 1'b1, 1'b1, 3);
        chk("badlane_done",  32'(DONE), 32'd1);
        chk("badlane_err",   32'(DONE_ERR), 32'd1);
        chk("badlane_steps", 32'(DONE_STEPS), 32'd0);
        chk("badlane_oor",   32'(DONE_OOR), 32'd0);
        chk("badlane_pause", 32'(HS_IO_CLK_PAUSE), 32'd0);
        chk("badlane_move",  32'(DELAY_LINE_MOVE), 32'd0);
        chk("badlane_load",  32'(DELAY_LINE_LOAD), 32'd0);
        step();
        chk("badlane_idle_ready", 32'(REQ_READY), 32'd1);
        chk("badlane_err_held",   32'(DONE_ERR), 32'd1);
        chk("badlane_done_drop",  32'(DONE), 32'd0);

        // Reserved op
        issue(1, 2'b10, 1'b0, 1'b0, 3);
        chk("resop_done",  32'(DONE), 32'd1);
        chk("resop_err",   32'(DONE_ERR), 32'd1);
        chk("resop_pause", 32'(HS_IO_CLK_PAUSE), 32'd0);
        chk("resop_load",  32'(DELAY_LINE_LOAD), 32'd0);
        step();

        // Zero-step move
        issue(3, 2'b00, 1'b1, 1'b1, 0);
        chk("zero_done",  32'(DONE), 32'd1);
        chk("zero_err",   32'(DONE_ERR), 32'd0);
        chk("zero_steps", 32'(DONE_STEPS), 32'd0);
        chk("zero_pause", 32'(HS_IO_CLK_PAUSE), 32'd0);
        step();
        chk("zero_pause_after", 32'(HS_IO_CLK_PAUSE), 32'd0);

        // Reset during GAP of a 10-step move
        issue(3, 2'b00, 1'b1, 1'b0, 10);
        step();
        step();
        chk("rstmid_move_t3", 32'(DELAY_LINE_MOVE), 32'(4'b1000));
        step();
        chk("rstmid_gap_pause", 32'(HS_IO_CLK_PAUSE), 32'(4'b1000));
        chk("rstmid_gap_move",  32'(DELAY_LINE_MOVE), 32'd0);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("rstmid_pause", 32'(HS_IO_CLK_PAUSE), 32'd0);
        chk("rstmid_sel",   32'(DELAY_LINE_SEL), 32'd0);
        chk("rstmid_move",  32'(DELAY_LINE_MOVE), 32'd0);
        chk("rstmid_ready", 32'(REQ_READY), 32'd1);
        chk("rstmid_done",  32'(DONE), 32'd0);
        step();
        chk("rstmid_done_hold", 32'(DONE), 32'd0);
        RESET_N = 1'b1;
        step();
        chk("rstrel_ready", 32'(REQ_READY), 32'd1);
        chk("rstrel_done",  32'(DONE), 32'd0);
        chk("rstrel_pause", 32'(HS_IO_CLK_PAUSE), 32'd0);

        // Normal operation after reset
        issue(2, 2'b01, 1'b1, 1'b0, 0);
        expect_op("ld2", 2, 1'b1, 1'b1, 1'b0, 0);
        issue(1, 2'b00, 1'b0, 1'b0, 2);
        expect_op("mv2", 1, 1'b0, 1'b0, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
